// File: rtl/multicycle_controller_if.sv
// Control bundle between the instruction-register fields, the multicycle
// controller and the datapath mux/enable inputs.
interface multicycle_controller_if #(
  parameter int STATE_W = 4
);
  logic [1:0]         op;
  logic [3:0]         cond;
  logic [5:0]         funct;
  logic [3:0]         rd;
  logic [3:0]         alu_flags;

  logic               pc_write;
  logic               adr_src;
  logic               mem_write;
  logic               ir_write;
  logic               reg_write;
  logic [1:0]         result_src;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         imm_src;
  logic [1:0]         reg_src;
  logic [1:0]         alu_ctl;
  logic               cond_ex;
  logic [STATE_W-1:0] state;

  modport master (
    output op, cond, funct, rd, alu_flags,
    input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, imm_src, reg_src, alu_ctl, cond_ex, state
  );

  modport slave (
    input  op, cond, funct, rd, alu_flags,
    output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, imm_src, reg_src, alu_ctl, cond_ex, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the shared memory/ALU datapath of a multicycle ARM core,
// with an NZCV flags register and condition-code evaluation.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  multicycle_controller_if.slave       bus
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 0,
    S_DECODE   = 1,
    S_MEMADR   = 2,
    S_MEMREAD  = 3,
    S_MEMWB    = 4,
    S_MEMWRITE = 5,
    S_EXECUTER = 6,
    S_EXECUTEI = 7,
    S_ALUWB    = 8,
    S_BRANCH   = 9
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_flags;
  logic        r_exec_ok;
  logic        w_n, w_z, w_c, w_v;
  logic        w_cond_ex;
  logic        w_in_execute;
  logic        w_rd_pc;
  logic [1:0]  w_dp_ctl;

  logic        w_pc_write, w_adr_src, w_mem_write, w_ir_write, w_reg_write;
  logic        w_alu_src_a;
  logic [1:0]  w_result_src, w_alu_src_b, w_alu_ctl;

  assign {w_n, w_z, w_c, w_v} = r_flags;
  assign w_in_execute = (r_state == S_EXECUTER) || (r_state == S_EXECUTEI);
  assign w_rd_pc      = (bus.rd == 4'd15);

  always_comb begin
    case (bus.cond)
      4'b0000: w_cond_ex = w_z;
      4'b0001: w_cond_ex = ~w_z;
      4'b0010: w_cond_ex = w_c;
      4'b0011: w_cond_ex = ~w_c;
      4'b0100: w_cond_ex = w_n;
      4'b0101: w_cond_ex = ~w_n;
      4'b0110: w_cond_ex = w_v;
      4'b0111: w_cond_ex = ~w_v;
      4'b1000: w_cond_ex = w_c & ~w_z;
      4'b1001: w_cond_ex = ~w_c | w_z;
      4'b1010: w_cond_ex = (w_n == w_v);
      4'b1011: w_cond_ex = (w_n != w_v);
      4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
      4'b1101: w_cond_ex = w_z | (w_n != w_v);
      4'b1110: w_cond_ex = 1'b1;
      default: w_cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    case (bus.funct[4:1])
      4'b0100: w_dp_ctl = 2'b00;
      4'b0010: w_dp_ctl = 2'b01;
      4'b0000: w_dp_ctl = 2'b10;
      4'b1100: w_dp_ctl = 2'b11;
      default: w_dp_ctl = 2'b00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // r_exec_ok keeps the pre-update condition so a flag-setting instruction's
  // own writeback is judged against the flags it started with.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags   <= 4'b0000;
      r_exec_ok <= 1'b0;
    end else if (w_in_execute) begin
      r_exec_ok <= w_cond_ex;
      if (bus.funct[0] && w_cond_ex) r_flags <= bus.alu_flags;
    end
  end

  // NOTE: every output and the next state get a default first, so no path
  // through the case can leave a variable unassigned and infer a latch.
  always_comb begin
    w_next       = S_FETCH;
    w_pc_write   = 1'b0;
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_result_src = 2'b00;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_alu_ctl    = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_ir_write   = 1'b1;
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_pc_write   = 1'b1;
        w_next       = S_DECODE;
      end
      S_DECODE: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        case (bus.op)
          2'b01:   w_next = S_MEMADR;
          2'b00:   w_next = bus.funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_b = 2'b01;
        w_next      = bus.funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_adr_src = 1'b1;
        w_next    = S_MEMWB;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = w_cond_ex;
        w_pc_write   = w_cond_ex & w_rd_pc;
      end
      S_MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = w_cond_ex;
      end
      S_EXECUTER: begin
        w_alu_ctl = w_dp_ctl;
        w_next    = S_ALUWB;
      end
      S_EXECUTEI: begin
        w_alu_src_b = 2'b01;
        w_alu_ctl   = w_dp_ctl;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = r_exec_ok;
        w_pc_write  = r_exec_ok & w_rd_pc;
      end
      S_BRANCH: begin
        w_alu_src_b  = 2'b01;
        w_result_src = 2'b10;
        w_pc_write   = w_cond_ex;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Enables are forced low combinationally so they drop the moment reset asserts.
  assign bus.pc_write   = w_pc_write  & reset;
  assign bus.ir_write   = w_ir_write  & reset;
  assign bus.mem_write  = w_mem_write & reset;
  assign bus.reg_write  = w_reg_write & reset;
  assign bus.adr_src    = w_adr_src;
  assign bus.result_src = w_result_src;
  assign bus.alu_src_a  = w_alu_src_a;
  assign bus.alu_src_b  = w_alu_src_b;
  assign bus.alu_ctl    = w_alu_ctl;
  assign bus.imm_src    = bus.op;
  assign bus.reg_src    = {bus.op == 2'b10, bus.op == 2'b01};
  assign bus.cond_ex    = w_cond_ex;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: directed instruction mix plus random instructions,
// compared cycle by cycle against an instruction-level reference model.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_controller_if #(.STATE_W(4)) bus ();

  multicycle_controller #(.STATE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int         total = 0;
  int         bad   = 0;
  logic [3:0] m_flags;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ARM-style condition: even code tests a predicate, odd code its inverse.
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v, base;
    {n, z, cf, v} = f;
    if (c == 4'hF) return 1'b0;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf & !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  function automatic logic [1:0] alu_of(input logic [5:0] f);
    case (f[4:1])
      4'd4:    return 2'b00;
      4'd2:    return 2'b01;
      4'd0:    return 2'b10;
      4'd12:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Control word: {pc_write, adr_src, mem_write, ir_write, reg_write,
  //                result_src, alu_src_a, alu_src_b, alu_ctl}
  function automatic logic [11:0] exp_ctl(input int st, input bit ok, input bit rd15,
                                          input logic [5:0] f);
    logic       pw = 0, as = 0, mw = 0, iw = 0, rw = 0, sa = 0;
    logic [1:0] rs = 0, sb = 0, ac = 0;
    case (st)
      0: begin iw = 1; sa = 1; sb = 2'd2; rs = 2'd2; pw = 1; end
      1: begin sa = 1; sb = 2'd2; rs = 2'd2; end
      2: sb = 2'd1;
      3: as = 1;
      4: begin rs = 2'd1; rw = ok; pw = ok & rd15; end
      5: begin as = 1; mw = ok; end
      6: ac = alu_of(f);
      7: begin sb = 2'd1; ac = alu_of(f); end
      8: begin rw = ok; pw = ok & rd15; end
      9: begin sb = 2'd1; rs = 2'd2; pw = ok; end
      default: ;
    endcase
    return {pw, as, mw, iw, rw, rs, sa, sb, ac};
  endfunction

  function automatic logic [11:0] obs_ctl();
    return {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.reg_write,
            bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_ctl};
  endfunction

  // Asserts reset, checks state/enables/cleared flags, then releases just after a rising edge.
  task automatic hold_reset();
    reset = 1'b0;
    #1;
    m_flags = 4'b0000;
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_enables", 32'({bus.pc_write, bus.mem_write, bus.ir_write, bus.reg_write}), 32'd0);
    for (int i = 0; i < 16; i++) begin
      bus.cond = 4'(i);
      #1;
      check($sformatf("rst_cond_ex c%0d", i), 32'(bus.cond_ex), 32'(cond_ok(4'(i), m_flags)));
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Entered 1 time unit after a rising edge with the DUT in FETCH.
  task automatic run_instr(input logic [1:0] op, input logic [3:0] cond, input logic [5:0] funct,
                           input logic [3:0] rd, input bit force_f, input logic [3:0] ff,
                           input int abort_at);
    int         seq[$];
    logic [3:0] pre, af;
    bit         ok;
    seq = {0, 1};
    case (op)
      2'b01:   if (funct[0]) seq = {0, 1, 2, 3, 4}; else seq = {0, 1, 2, 5};
      2'b00:   seq = {0, 1, funct[5] ? 7 : 6, 8};
      2'b10:   seq = {0, 1, 9};
      default: ;
    endcase
    bus.op = op; bus.cond = cond; bus.funct = funct; bus.rd = rd;
    pre = m_flags;
    ok  = cond_ok(cond, pre);
    for (int k = 0; k < seq.size(); k++) begin
      af = force_f ? ff : 4'($urandom);
      bus.alu_flags = af;
      #1;
      check($sformatf("state op%0d k%0d", op, k), 32'(bus.state), 32'(seq[k]));
      check($sformatf("ctl s%0d", seq[k]), 32'(obs_ctl()),
            32'(exp_ctl(seq[k], ok, rd == 4'd15, funct)));
      check($sformatf("cond_ex s%0d c%0d", seq[k], cond), 32'(bus.cond_ex),
            32'(cond_ok(cond, m_flags)));
      check("imm_reg_src", 32'({bus.imm_src, bus.reg_src}),
            32'({op, op == 2'b10, op == 2'b01}));
      if (k == abort_at) begin
        hold_reset();
        return;
      end
      if ((seq[k] == 6 || seq[k] == 7) && funct[0] && ok) m_flags = af;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.op = 2'b00; bus.cond = 4'hE; bus.funct = 6'd0; bus.rd = 4'd0; bus.alu_flags = 4'd0;
    m_flags = 4'b0000;
    #2;
    hold_reset();

    run_instr(2'b00, 4'hE, 6'b001000, 4'd1,  0, 4'h0, -1);  // ADD
    run_instr(2'b01, 4'hE, 6'b000001, 4'd2,  0, 4'h0, -1);  // LDR
    run_instr(2'b01, 4'hE, 6'b000001, 4'd15, 0, 4'h0, -1);  // LDR to PC
    run_instr(2'b01, 4'hE, 6'b000000, 4'd3,  0, 4'h0, -1);  // STR
    run_instr(2'b00, 4'hE, 6'b000101, 4'd4,  1, 4'h4, -1);  // SUBS -> Z
    run_instr(2'b10, 4'h0, 6'b100000, 4'd0,  0, 4'h0, -1);  // BEQ taken
    run_instr(2'b10, 4'h1, 6'b100000, 4'd0,  0, 4'h0, -1);  // BNE not taken
    run_instr(2'b00, 4'hE, 6'b111000, 4'd5,  0, 4'h0, -1);  // ORR imm
    run_instr(2'b00, 4'hE, 6'b000000, 4'd6,  0, 4'h0, -1);  // AND
    run_instr(2'b00, 4'hF, 6'b001000, 4'd7,  0, 4'h0, -1);  // never
    run_instr(2'b00, 4'h0, 6'b000101, 4'd15, 1, 4'h0, -1);  // SUBSEQ clears Z, still writes
    run_instr(2'b00, 4'hE, 6'b000101, 4'd4,  1, 4'h4, -1);  // SUBS -> Z again
    run_instr(2'b01, 4'hE, 6'b000001, 4'd8,  0, 4'h0, 3);   // LDR, reset in MEMREAD
    run_instr(2'b10, 4'h0, 6'b100000, 4'd0,  0, 4'h0, -1);  // BEQ after flag clear
    run_instr(2'b11, 4'hE, 6'b000000, 4'd0,  0, 4'h0, -1);  // undefined op

    for (int i = 0; i < 150; i++) begin
      run_instr(2'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom),
                6'($urandom),
                ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom),
                0, 4'h0, -1);
    end

    #1;
    check("final_state", 32'(bus.state), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
